clk_div_multi: RTL

Parametrised, multi-channel successor to the single fixed-ratio divider. From the board clock it produces NUM_CH independent square-wave divided clocks. Each channel also produces a one-cycle tick strobe on every toggle. Half-periods are runtime-programmable through a simple write port and are applied glitch-free. The block feeds display scan, key debounce and LED blink logic, which currently each carry their own hard-coded divider.

---
 rtl/clk_div_multi.sv | 84 ++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel square wave plus a
// one-cycle tick on every toggle, with glitch-free runtime half-period updates.
module clk_div_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 29,
    parameter int CH_W         = 2,
    parameter int DEFAULT_HALF = 6800000
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

    // A programmed half-period of zero behaves as one (toggle every cycle).
    function automatic logic [CNT_W-1:0] eff_half(input logic [CNT_W-1:0] half);
        return (half == '0) ? CNT_W'(1) : half;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act;
        logic [CNT_W-1:0] shd;
        logic [CNT_W-1:0] last_cnt;
        logic             div_r;
        logic             tick_r;
        logic             wr;
        logic             tc;
        logic             reload;

        // Out-of-range channel indices match no channel and are dropped.
        assign wr       = cfg_we && (cfg_ch == CH_W'(i));
        assign last_cnt = eff_half(act) - CNT_W'(1);
        assign tc       = (cnt == last_cnt);
        assign reload   = sync || !en[i] || tc;

        always_ff @(posedge clk_50m or negedge rst_n) begin
            if (!rst_n) begin
                shd <= RST_HALF;
            end else if (wr) begin
                shd <= cfg_half;
            end
        end

        // act only moves at a period boundary; a coincident write bypasses shd.
        always_ff @(posedge clk_50m or negedge rst_n) begin
            if (!rst_n) begin
                act <= RST_HALF;
            end else if (reload) begin
                act <= wr ? cfg_half : shd;
            end
        end

        always_ff @(posedge clk_50m or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                div_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (sync || !en[i]) begin
                cnt    <= '0;
                div_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (tc) begin
                cnt    <= '0;
                div_r  <= ~div_r;
                tick_r <= 1'b1;
            end else begin
                cnt    <= cnt + CNT_W'(1);
                tick_r <= 1'b0;
            end
        end

        assign div_out[i] = div_r;
        assign tick[i]    = tick_r;
    end

endmodule
